rename_group: RTL and testbench
===============================

RENAME_GROUP -- requirements
Module: rename_group

Interface
REQ-001 SHALL have parameter WIDTH, default 2, lanes renamed per cycle (1..4).
REQ-002 SHALL have parameter LOG_ARCH, default 5; NUM_ARCH = 2**LOG_ARCH.
REQ-003 SHALL have parameter LOG_PHYS, default 6; CNT_BITS = $clog2(WIDTH+1).
REQ-004 CLK  in  1  single clock, rising edge.
REQ-005 RESET  in  1  asynchronous, active-low.
REQ-006 Flush_IN  in  1  mispredict/exception flush.
REQ-007 Arch_map_IN  in  NUM_ARCH*LOG_PHYS  committed (retirement) map.
REQ-008 In_valid  in  WIDTH  per-lane valid; lane 0 oldest; prefix-contiguous.
REQ-009 In_src_a, In_src_b, In_dst  in  WIDTH*LOG_ARCH each  architectural regs.
REQ-010 In_regwrite, In_mem  in  WIDTH each  writes a reg / needs an LSQ slot.
REQ-011 In_accept  out  CNT_BITS  lanes consumed this cycle (combinational).
REQ-012 Free_reg  in  WIDTH*LOG_PHYS  free-list head entries; Free_count  in  CNT_BITS.
REQ-013 Free_pop  out  CNT_BITS  registers taken from free list (combinational).
REQ-014 ROB_free, IQ_free, LSQ_free  in  CNT_BITS each  free slots, saturated at WIDTH.
REQ-015 Busy_IN  in  2**LOG_PHYS  physical busy bits.
REQ-016 Out_valid  out  WIDTH  registered lane valid.
REQ-017 Out_src_a_phys, Out_src_b_phys, Out_dst_phys, Out_old_phys  out  WIDTH*LOG_PHYS each.
REQ-018 Out_src_a_rdy, Out_src_b_rdy, Out_regwrite  out  WIDTH each.
REQ-019 Blocked  out  1  registered: valid input present but not fully accepted.

Function
REQ-020 Block SHALL hold speculative RAT: NUM_ARCH entries of LOG_PHYS bits.
REQ-021 Effective writer: In_regwrite && In_dst != 0; arch reg 0 never renamed, always phys 0, ready.
REQ-022 Accept count n SHALL be largest k, lanes 0..k-1 valid, with writers(0..k-1) <= Free_count, k <= ROB_free, k <= IQ_free, mem(0..k-1) <= LSQ_free.
REQ-023 Accepted writer lane SHALL receive Free_reg[j], j = writers among older accepted lanes; Free_pop = writers(0..n-1).
REQ-024 Source lookup SHALL forward from youngest older accepted in-group writer of same arch reg, rdy=0; else RAT entry, rdy = !Busy_IN[phys].
REQ-025 Out_old_phys SHALL be previous mapping of In_dst, including in-group forwarding; same-dst writers chain correctly.
REQ-026 RAT update at clock edge: youngest accepted writer per arch reg wins.
REQ-027 Outputs SHALL be registered, latency 1 cycle; non-accepted lanes Out_valid=0.
REQ-028 FSM states: IDLE (no valid input), RUN (all valid lanes accepted), STALL (partial/zero accept), FLUSH.
REQ-029 Transitions: any -> FLUSH on Flush_IN; FLUSH -> IDLE after one cycle; else next state from current input/accept result.
REQ-030 Flush_IN SHALL have priority: RAT <= Arch_map_IN, In_accept=0, Free_pop=0, Out_valid cleared next edge.
REQ-031 In FLUSH state In_accept SHALL be 0 (one bubble cycle).
REQ-032 Blocked=1 when state STALL, else 0.
REQ-033 Non-prefix In_valid: only leading contiguous valid lanes considered.

Reset
REQ-034 On RESET low: RAT[i]=i, all Out_* 0, Blocked=0, state IDLE, independent of CLK.
REQ-035 Reset mid-operation SHALL discard in-flight group; no free-list pop that cycle.

Structure
REQ-036 Shared package SHALL hold FSM state enum, default parameters, lane-record field widths.
REQ-037 Sub-module rename_lane_lookup SHALL do per-lane source/old-dst lookup with in-group forwarding; instantiated WIDTH times.

Verification
REQ-038 WIDTH=2, lanes add r3<-r1,r2 / add r4<-r3,r1, Free_reg={40,41}, all free=2 -> accept 2, lane1 src_a=40 rdy=0, RAT[3]=40, RAT[4]=41.
REQ-039 Free_count=1, both lanes write -> In_accept=1, Free_pop=1, Blocked=1 next cycle, lane1 Out_valid=0.
REQ-040 Both lanes write r5, Free_reg={50,51}, RAT[5]=5 -> old_phys {5,50}, RAT[5]=51.
REQ-041 Flush_IN with Arch_map_IN[3]=12 while valid input -> In_accept=0, RAT[3]=12, Out_valid=0, one bubble cycle.
REQ-042 In_dst=0 with regwrite, Free_count=0 -> accepted, Free_pop=0, Out_regwrite=0.
REQ-043 RESET low mid-stream -> all outputs 0 immediately, RAT[7]=7 after release.

Source files
------------

// File: rtl/rename_group_pkg.sv
// Shared types and default sizing for the register-rename group.
// The lane-record fields are LOG_ARCH-bit architectural and LOG_PHYS-bit physical register numbers.
package rename_group_pkg;

  localparam int DEF_WIDTH    = 2;
  localparam int DEF_LOG_ARCH = 5;
  localparam int DEF_LOG_PHYS = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } rename_state_e;

endpackage

// File: rtl/rename_group_lane_lookup.sv
// Per-lane source and old-destination lookup.
// Values written by older lanes of the same group take priority over the RAT.
module rename_lane_lookup
  import rename_group_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOG_ARCH = DEF_LOG_ARCH,
  parameter int LOG_PHYS = DEF_LOG_PHYS
) (
  input  logic [LOG_ARCH-1:0]               i_src_a,
  input  logic [LOG_ARCH-1:0]               i_src_b,
  input  logic [LOG_ARCH-1:0]               i_dst,
  input  logic [(2**LOG_ARCH)*LOG_PHYS-1:0] i_rat,
  input  logic [(2**LOG_PHYS)-1:0]          i_busy,
  input  logic [WIDTH-1:0]                  i_grp_writer,
  input  logic [WIDTH*LOG_ARCH-1:0]         i_grp_dst,
  input  logic [WIDTH*LOG_PHYS-1:0]         i_grp_phys,
  output logic [LOG_PHYS-1:0]               o_src_a_phys,
  output logic                              o_src_a_rdy,
  output logic [LOG_PHYS-1:0]               o_src_b_phys,
  output logic                              o_src_b_rdy,
  output logic [LOG_PHYS-1:0]               o_old_phys
);

  // i_grp_writer only flags accepted writers older than this lane; scanning
  // upward leaves the youngest matching one in place.
  always_comb begin
    o_src_a_phys = i_rat[int'(i_src_a)*LOG_PHYS +: LOG_PHYS];
    o_src_b_phys = i_rat[int'(i_src_b)*LOG_PHYS +: LOG_PHYS];
    o_old_phys   = i_rat[int'(i_dst)*LOG_PHYS +: LOG_PHYS];
    o_src_a_rdy  = ~i_busy[o_src_a_phys];
    o_src_b_rdy  = ~i_busy[o_src_b_phys];
    for (int j = 0; j < WIDTH; j++) begin
      if (i_grp_writer[j]) begin
        if (i_grp_dst[j*LOG_ARCH +: LOG_ARCH] == i_src_a) begin
          o_src_a_phys = i_grp_phys[j*LOG_PHYS +: LOG_PHYS];
          o_src_a_rdy  = 1'b0;
        end
        if (i_grp_dst[j*LOG_ARCH +: LOG_ARCH] == i_src_b) begin
          o_src_b_phys = i_grp_phys[j*LOG_PHYS +: LOG_PHYS];
          o_src_b_rdy  = 1'b0;
        end
        if (i_grp_dst[j*LOG_ARCH +: LOG_ARCH] == i_dst) begin
          o_old_phys = i_grp_phys[j*LOG_PHYS +: LOG_PHYS];
        end
      end
    end
    if (i_src_a == '0) begin
      o_src_a_phys = '0;
      o_src_a_rdy  = 1'b1;
    end
    if (i_src_b == '0) begin
      o_src_b_phys = '0;
      o_src_b_rdy  = 1'b1;
    end
    if (i_dst == '0) begin
      o_old_phys = '0;
    end
  end

endmodule

// File: rtl/rename_group.sv
// Multi-lane register rename stage with a speculative RAT, resource-limited
// in-order acceptance and a flush that restores the committed map.
module rename_group
  import rename_group_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOG_ARCH = DEF_LOG_ARCH,
  parameter int LOG_PHYS = DEF_LOG_PHYS
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_flush,
  input  logic [(2**LOG_ARCH)*LOG_PHYS-1:0]   i_arch_map,
  input  logic [WIDTH-1:0]                    i_in_valid,
  input  logic [WIDTH*LOG_ARCH-1:0]           i_in_src_a,
  input  logic [WIDTH*LOG_ARCH-1:0]           i_in_src_b,
  input  logic [WIDTH*LOG_ARCH-1:0]           i_in_dst,
  input  logic [WIDTH-1:0]                    i_in_regwrite,
  input  logic [WIDTH-1:0]                    i_in_mem,
  output logic [$clog2(WIDTH+1)-1:0]          o_in_accept,
  input  logic [WIDTH*LOG_PHYS-1:0]           i_free_reg,
  input  logic [$clog2(WIDTH+1)-1:0]          i_free_count,
  output logic [$clog2(WIDTH+1)-1:0]          o_free_pop,
  input  logic [$clog2(WIDTH+1)-1:0]          i_rob_free,
  input  logic [$clog2(WIDTH+1)-1:0]          i_iq_free,
  input  logic [$clog2(WIDTH+1)-1:0]          i_lsq_free,
  input  logic [(2**LOG_PHYS)-1:0]            i_busy,
  output logic [WIDTH-1:0]                    o_out_valid,
  output logic [WIDTH*LOG_PHYS-1:0]           o_out_src_a_phys,
  output logic [WIDTH*LOG_PHYS-1:0]           o_out_src_b_phys,
  output logic [WIDTH*LOG_PHYS-1:0]           o_out_dst_phys,
  output logic [WIDTH*LOG_PHYS-1:0]           o_out_old_phys,
  output logic [WIDTH-1:0]                    o_out_src_a_rdy,
  output logic [WIDTH-1:0]                    o_out_src_b_rdy,
  output logic [WIDTH-1:0]                    o_out_regwrite,
  output logic                                o_blocked
);

  localparam int NUM_ARCH = 2**LOG_ARCH;
  localparam int CNT_BITS = $clog2(WIDTH+1);

  rename_state_e                      r_state;
  logic [LOG_PHYS-1:0]                r_rat [NUM_ARCH];
  logic [NUM_ARCH*LOG_PHYS-1:0]       w_rat_flat;
  logic [WIDTH-1:0]                   w_writer;
  logic [WIDTH-1:0]                   w_acc;
  logic [CNT_BITS-1:0]                w_prefix;
  logic [CNT_BITS-1:0]                w_accept;
  logic [WIDTH-1:0][LOG_PHYS-1:0]     w_new_phys;
  logic [WIDTH-1:0][WIDTH-1:0]        w_older;
  logic [WIDTH-1:0][LOG_PHYS-1:0]     w_src_a_phys;
  logic [WIDTH-1:0][LOG_PHYS-1:0]     w_src_b_phys;
  logic [WIDTH-1:0][LOG_PHYS-1:0]     w_old_phys;
  logic [WIDTH-1:0]                   w_src_a_rdy;
  logic [WIDTH-1:0]                   w_src_b_rdy;

  // Acceptance stops at the first lane that breaks the valid prefix or exceeds any resource.
  always_comb begin
    int nPrefix, nAcc, nWr, nMem, popCnt;
    logic prefixOk, fitOk;
    nPrefix  = 0;
    nAcc     = 0;
    nWr      = 0;
    nMem     = 0;
    popCnt   = 0;
    prefixOk = 1'b1;
    fitOk    = 1'b1;
    w_writer = '0;
    w_acc    = '0;
    w_older  = '0;
    w_new_phys = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_writer[k] = i_in_regwrite[k] && (i_in_dst[k*LOG_ARCH +: LOG_ARCH] != '0);
      prefixOk = prefixOk && i_in_valid[k];
      if (prefixOk) begin
        nPrefix = k + 1;
        nWr  = nWr + int'(w_writer[k]);
        nMem = nMem + int'(i_in_mem[k]);
        fitOk = fitOk && (nWr <= int'(i_free_count)) && ((k + 1) <= int'(i_rob_free))
                && ((k + 1) <= int'(i_iq_free)) && (nMem <= int'(i_lsq_free));
        if (fitOk) nAcc = k + 1;
      end
    end
    if (i_flush || (r_state == ST_FLUSH) || !rst_n) nAcc = 0;
    for (int i = 0; i < WIDTH; i++) begin
      w_acc[i]      = (i < nAcc);
      w_new_phys[i] = i_free_reg[popCnt*LOG_PHYS +: LOG_PHYS];
      for (int j = 0; j < i; j++) w_older[i][j] = w_acc[j] && w_writer[j];
      if (w_acc[i] && w_writer[i]) popCnt = popCnt + 1;
    end
    w_prefix    = CNT_BITS'(nPrefix);
    w_accept    = CNT_BITS'(nAcc);
    o_in_accept = CNT_BITS'(nAcc);
    o_free_pop  = CNT_BITS'(popCnt);
  end

  always_comb begin
    w_rat_flat = '0;
    for (int a = 0; a < NUM_ARCH; a++) w_rat_flat[a*LOG_PHYS +: LOG_PHYS] = r_rat[a];
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    rename_lane_lookup #(
      .WIDTH    (WIDTH),
      .LOG_ARCH (LOG_ARCH),
      .LOG_PHYS (LOG_PHYS)
    ) u_lookup (
      .i_src_a      (i_in_src_a[g*LOG_ARCH +: LOG_ARCH]),
      .i_src_b      (i_in_src_b[g*LOG_ARCH +: LOG_ARCH]),
      .i_dst        (i_in_dst[g*LOG_ARCH +: LOG_ARCH]),
      .i_rat        (w_rat_flat),
      .i_busy       (i_busy),
      .i_grp_writer (w_older[g]),
      .i_grp_dst    (i_in_dst),
      .i_grp_phys   (w_new_phys),
      .o_src_a_phys (w_src_a_phys[g]),
      .o_src_a_rdy  (w_src_a_rdy[g]),
      .o_src_b_phys (w_src_b_phys[g]),
      .o_src_b_rdy  (w_src_b_rdy[g]),
      .o_old_phys   (w_old_phys[g])
    );
  end

  // Later lanes are assigned last, so the youngest writer of an arch reg wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < NUM_ARCH; a++) r_rat[a] <= LOG_PHYS'(a);
      o_out_valid      <= '0;
      o_out_src_a_phys <= '0;
      o_out_src_b_phys <= '0;
      o_out_dst_phys   <= '0;
      o_out_old_phys   <= '0;
      o_out_src_a_rdy  <= '0;
      o_out_src_b_rdy  <= '0;
      o_out_regwrite   <= '0;
    end else begin
      if (i_flush) begin
        for (int a = 0; a < NUM_ARCH; a++) r_rat[a] <= i_arch_map[a*LOG_PHYS +: LOG_PHYS];
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (w_acc[i] && w_writer[i]) r_rat[i_in_dst[i*LOG_ARCH +: LOG_ARCH]] <= w_new_phys[i];
        end
      end
      for (int i = 0; i < WIDTH; i++) begin
        o_out_valid[i]                         <= w_acc[i];
        o_out_src_a_phys[i*LOG_PHYS +: LOG_PHYS] <= w_acc[i] ? w_src_a_phys[i] : '0;
        o_out_src_b_phys[i*LOG_PHYS +: LOG_PHYS] <= w_acc[i] ? w_src_b_phys[i] : '0;
        o_out_dst_phys[i*LOG_PHYS +: LOG_PHYS]   <= (w_acc[i] && w_writer[i]) ? w_new_phys[i] : '0;
        o_out_old_phys[i*LOG_PHYS +: LOG_PHYS]   <= w_acc[i] ? w_old_phys[i] : '0;
        o_out_src_a_rdy[i]                     <= w_acc[i] && w_src_a_rdy[i];
        o_out_src_b_rdy[i]                     <= w_acc[i] && w_src_b_rdy[i];
        o_out_regwrite[i]                      <= w_acc[i] && w_writer[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      o_blocked <= 1'b0;
    end else if (i_flush) begin
      r_state   <= ST_FLUSH;
      o_blocked <= 1'b0;
    end else if (r_state == ST_FLUSH || w_prefix == '0) begin
      r_state   <= ST_IDLE;
      o_blocked <= 1'b0;
    end else if (w_accept == w_prefix) begin
      r_state   <= ST_RUN;
      o_blocked <= 1'b0;
    end else begin
      r_state   <= ST_STALL;
      o_blocked <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rename_group.sv
// Directed-vector bench for rename_group at WIDTH=2, LOG_ARCH=5, LOG_PHYS=6.
// Inputs change on the falling edge; registered outputs are sampled 1 ns after the rising edge.
module tb_rename_group;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [191:0] archMap;
  logic [1:0]  inValid, inRegwrite, inMem;
  logic [9:0]  inSrcA, inSrcB, inDst;
  logic [1:0]  inAccept, freePop, freeCount, robFree, iqFree, lsqFree;
  logic [11:0] freeReg;
  logic [63:0] busy;
  logic [1:0]  outValid, outSrcARdy, outSrcBRdy, outRegwrite;
  logic [11:0] outSrcAPhys, outSrcBPhys, outDstPhys, outOldPhys;
  logic        blocked;
  int          vectors = 0;
  int          misses  = 0;

  always #5 clk = ~clk;

  rename_group dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_flush          (flush),
    .i_arch_map       (archMap),
    .i_in_valid       (inValid),
    .i_in_src_a       (inSrcA),
    .i_in_src_b       (inSrcB),
    .i_in_dst         (inDst),
    .i_in_regwrite    (inRegwrite),
    .i_in_mem         (inMem),
    .o_in_accept      (inAccept),
    .i_free_reg       (freeReg),
    .i_free_count     (freeCount),
    .o_free_pop       (freePop),
    .i_rob_free       (robFree),
    .i_iq_free        (iqFree),
    .i_lsq_free       (lsqFree),
    .i_busy           (busy),
    .o_out_valid      (outValid),
    .o_out_src_a_phys (outSrcAPhys),
    .o_out_src_b_phys (outSrcBPhys),
    .o_out_dst_phys   (outDstPhys),
    .o_out_old_phys   (outOldPhys),
    .o_out_src_a_rdy  (outSrcARdy),
    .o_out_src_b_rdy  (outSrcBRdy),
    .o_out_regwrite   (outRegwrite),
    .o_blocked        (blocked)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed != expected) begin
      misses++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int phys(input logic [11:0] v, input int lane);
    return int'(v[lane*6 +: 6]);
  endfunction

  // Lane fields: valid, regwrite, mem, dst, src_a, src_b for lanes 0 and 1.
  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] rw, input logic [1:0] m,
                               input int d0, input int a0, input int b0,
                               input int d1, input int a1, input int b1);
    inValid    = v;
    inRegwrite = rw;
    inMem      = m;
    inDst      = {5'(d1), 5'(d0)};
    inSrcA     = {5'(a1), 5'(a0)};
    inSrcB     = {5'(b1), 5'(b0)};
  endtask

  task automatic setResources(input int fc, input int rob, input int iq, input int lsq,
                              input int f0, input int f1);
    freeCount = 2'(fc);
    robFree   = 2'(rob);
    iqFree    = 2'(iq);
    lsqFree   = 2'(lsq);
    freeReg   = {6'(f1), 6'(f0)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    busy  = '0;
    for (int a = 0; a < 32; a++) archMap[a*6 +: 6] = (a == 3) ? 6'd12 : 6'(a);
    applyStimulus(2'b11, 2'b11, 2'b00, 3, 1, 2, 4, 3, 1);
    setResources(2, 2, 2, 2, 40, 41);
    #2;
    checkOutput("reset_valid", outValid, 0);
    checkOutput("reset_blocked", blocked, 0);
    checkOutput("reset_accept", inAccept, 0);
    checkOutput("reset_pop", freePop, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // add r3<-r1,r2 ; add r4<-r3,r1 with forwarding of r3
    #1;
    checkOutput("grp_accept", inAccept, 2);
    checkOutput("grp_pop", freePop, 2);
    tick();
    checkOutput("grp_valid", outValid, 3);
    checkOutput("grp_l0_dst", phys(outDstPhys, 0), 40);
    checkOutput("grp_l0_old", phys(outOldPhys, 0), 3);
    checkOutput("grp_l0_srca", phys(outSrcAPhys, 0), 1);
    checkOutput("grp_l1_srca", phys(outSrcAPhys, 1), 40);
    checkOutput("grp_l1_srca_rdy", outSrcARdy[1], 0);
    checkOutput("grp_l1_srcb", phys(outSrcBPhys, 1), 1);
    checkOutput("grp_l1_dst", phys(outDstPhys, 1), 41);
    checkOutput("grp_l1_old", phys(outOldPhys, 1), 4);
    checkOutput("grp_blocked", blocked, 0);

    // read back RAT[3], RAT[4]; phys 41 busy
    @(negedge clk);
    applyStimulus(2'b01, 2'b00, 2'b00, 0, 3, 4, 0, 0, 0);
    busy = 64'd1 << 41;
    #1;
    checkOutput("rat_accept", inAccept, 1);
    checkOutput("rat_pop", freePop, 0);
    tick();
    checkOutput("rat_valid", outValid, 1);
    checkOutput("rat3", phys(outSrcAPhys, 0), 40);
    checkOutput("rat4", phys(outSrcBPhys, 0), 41);
    checkOutput("rat3_rdy", outSrcARdy[0], 1);
    checkOutput("rat4_rdy", outSrcBRdy[0], 0);

    // only one free register for two writers
    @(negedge clk);
    busy = '0;
    applyStimulus(2'b11, 2'b11, 2'b00, 6, 1, 1, 7, 1, 1);
    setResources(1, 2, 2, 2, 20, 21);
    #1;
    checkOutput("fc1_accept", inAccept, 1);
    checkOutput("fc1_pop", freePop, 1);
    tick();
    checkOutput("fc1_blocked", blocked, 1);
    checkOutput("fc1_valid", outValid, 1);
    checkOutput("fc1_dst", phys(outDstPhys, 0), 20);

    // two writers of r5 chain their old mappings
    @(negedge clk);
    applyStimulus(2'b11, 2'b11, 2'b00, 5, 1, 1, 5, 1, 1);
    setResources(2, 2, 2, 2, 50, 51);
    #1;
    checkOutput("r5_accept", inAccept, 2);
    tick();
    checkOutput("r5_old0", phys(outOldPhys, 0), 5);
    checkOutput("r5_old1", phys(outOldPhys, 1), 50);
    checkOutput("r5_blocked", blocked, 0);

    // RAT[5]=51, RAT[6]=20, RAT[7] untouched; arch reg 0 ready despite busy[0]
    @(negedge clk);
    applyStimulus(2'b11, 2'b00, 2'b00, 0, 5, 6, 0, 7, 0);
    busy = (64'd1 << 0) | (64'd1 << 20);
    tick();
    checkOutput("rat5", phys(outSrcAPhys, 0), 51);
    checkOutput("rat6", phys(outSrcBPhys, 0), 20);
    checkOutput("rat6_rdy", outSrcBRdy[0], 0);
    checkOutput("rat7", phys(outSrcAPhys, 1), 7);
    checkOutput("r0_phys", phys(outSrcBPhys, 1), 0);
    checkOutput("r0_rdy", outSrcBRdy[1], 1);

    // write to r0 needs no free register
    @(negedge clk);
    busy = '0;
    applyStimulus(2'b01, 2'b01, 2'b00, 0, 1, 2, 0, 0, 0);
    setResources(0, 2, 2, 2, 60, 61);
    #1;
    checkOutput("r0w_accept", inAccept, 1);
    checkOutput("r0w_pop", freePop, 0);
    tick();
    checkOutput("r0w_valid", outValid, 1);
    checkOutput("r0w_regwrite", outRegwrite, 0);
    checkOutput("r0w_dst", phys(outDstPhys, 0), 0);

    // LSQ limits to one lane, then ROB limits to zero
    @(negedge clk);
    applyStimulus(2'b11, 2'b00, 2'b11, 0, 1, 1, 0, 1, 1);
    setResources(2, 2, 2, 1, 60, 61);
    #1;
    checkOutput("lsq_accept", inAccept, 1);
    tick();
    checkOutput("lsq_blocked", blocked, 1);
    @(negedge clk);
    setResources(2, 0, 2, 2, 60, 61);
    #1;
    checkOutput("rob_accept", inAccept, 0);
    tick();
    checkOutput("rob_valid", outValid, 0);
    checkOutput("rob_blocked", blocked, 1);

    // non-prefix valid: nothing considered, state goes idle
    @(negedge clk);
    applyStimulus(2'b10, 2'b00, 2'b00, 0, 1, 1, 0, 1, 1);
    setResources(2, 2, 2, 2, 60, 61);
    #1;
    checkOutput("np_accept", inAccept, 0);
    tick();
    checkOutput("np_valid", outValid, 0);
    checkOutput("np_blocked", blocked, 0);

    // flush with valid writers present, then one bubble cycle
    @(negedge clk);
    applyStimulus(2'b11, 2'b11, 2'b00, 8, 1, 1, 9, 1, 1);
    flush = 1'b1;
    #1;
    checkOutput("fl_accept", inAccept, 0);
    checkOutput("fl_pop", freePop, 0);
    tick();
    checkOutput("fl_valid", outValid, 0);
    checkOutput("fl_blocked", blocked, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("bubble_accept", inAccept, 0);
    checkOutput("bubble_pop", freePop, 0);
    tick();
    checkOutput("bubble_valid", outValid, 0);
    @(negedge clk);
    applyStimulus(2'b11, 2'b00, 2'b00, 0, 3, 1, 0, 8, 1);
    #1;
    checkOutput("postfl_accept", inAccept, 2);
    tick();
    checkOutput("postfl_rat3", phys(outSrcAPhys, 0), 12);
    checkOutput("postfl_rat8", phys(outSrcAPhys, 1), 8);

    // build a stalled state with RAT[7]=30, then reset mid-cycle
    @(negedge clk);
    applyStimulus(2'b11, 2'b11, 2'b00, 7, 1, 1, 10, 1, 1);
    setResources(1, 2, 2, 2, 30, 31);
    tick();
    checkOutput("pre_rst_blocked", blocked, 1);
    checkOutput("pre_rst_valid", outValid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_blocked", blocked, 0);
    checkOutput("rst_accept", inAccept, 0);
    checkOutput("rst_pop", freePop, 0);
    checkOutput("rst_dst", phys(outDstPhys, 0), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b11, 2'b00, 2'b00, 0, 7, 3, 0, 10, 1);
    setResources(2, 2, 2, 2, 30, 31);
    tick();
    checkOutput("postrst_rat7", phys(outSrcAPhys, 0), 7);
    checkOutput("postrst_rat3", phys(outSrcBPhys, 0), 3);
    checkOutput("postrst_rat10", phys(outSrcAPhys, 1), 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
